// File: rtl/rx_byte_writer.sv
// rx_byte_writer: assembles LSB-first decoded bits into bytes after SYNC and
// writes them to a downstream FIFO, flagging overflow and partial-byte EOPs.
module rx_byte_writer #(
    parameter int                   BUS_WIDTH    = 8,
    parameter logic [BUS_WIDTH-1:0] SYNC_PATTERN = 8'h80,
    parameter int                   MAX_BYTES    = 1023
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clear,
    input  logic                 bit_valid,
    input  logic                 d_bit,
    input  logic                 eop,
    input  logic                 fifo_full,
    output logic                 w_enable,
    output logic [BUS_WIDTH-1:0] data_o,
    output logic [9:0]           byte_cnt,
    output logic                 pkt_done,
    output logic                 rx_error,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, DATA, ERR} state_t;
    localparam logic [2:0] LAST  = 3'(BUS_WIDTH - 1);
    localparam logic [9:0] MAX_C = 10'(MAX_BYTES);
    state_t               state_q, state_d;
    logic [BUS_WIDTH-1:0] shift_q, shift_d, data_q, data_d, shifted;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [9:0]           byte_cnt_q, byte_cnt_d;
    logic                 wen_q, wen_d, done_q, done_d, err_q, err_d, take_bit;
    // eop wins over a coincident bit, so that bit never enters the shifter
    assign take_bit = bit_valid && !eop;
    assign shifted  = {d_bit, shift_q[BUS_WIDTH-1:1]};
    always_comb begin
        state_d    = state_q;
        shift_d    = take_bit ? shifted : shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        data_d     = data_q;
        wen_d      = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        if (clear) begin
            state_d    = IDLE;
            shift_d    = '0;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            err_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (take_bit && shifted == SYNC_PATTERN) begin
                    state_d    = DATA;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    err_d      = 1'b0;
                end
                DATA: if (eop) begin
                    state_d = IDLE;
                    done_d  = bit_cnt_q == 3'd0;
                    err_d   = err_q || bit_cnt_q != 3'd0;
                end else if (take_bit) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST) begin
                        if (fifo_full || byte_cnt_q == MAX_C) begin
                            state_d = ERR;
                            err_d   = 1'b1;
                        end else begin
                            wen_d      = 1'b1;
                            data_d     = shifted;
                            byte_cnt_d = byte_cnt_q + 10'd1;
                        end
                    end
                end
                ERR: state_d = eop ? IDLE : ERR;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            data_q     <= '0;
            wen_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            data_q     <= data_d;
            wen_q      <= wen_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end
    assign w_enable = wen_q;
    assign data_o   = data_q;
    assign byte_cnt = byte_cnt_q;
    assign pkt_done = done_q;
    assign rx_error = err_q;
    assign busy     = state_q != IDLE;
endmodule

// File: doc/rx_byte_writer.md
RX_BYTE_WRITER -- requirements
Module: rx_byte_writer

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 8, giving the byte width written to the downstream FIFO.
REQ-002 SHALL have parameter SYNC_PATTERN, default 8'h80, giving the decoded SYNC byte as assembled LSB-first.
REQ-003 SHALL have parameter MAX_BYTES, default 1023, giving the byte_cnt saturation value.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 n_rst  input  1  asynchronous active-low reset.
REQ-006 clear  input  1  synchronous abort; returns to IDLE and clears counters.
REQ-007 bit_valid  input  1  one-cycle strobe qualifying d_bit.
REQ-008 d_bit  input  1  decoded (post-NRZI, post-unstuff) serial bit.
REQ-009 eop  input  1  one-cycle end-of-packet strobe.
REQ-010 fifo_full  input  1  downstream FIFO full flag.
REQ-011 w_enable  output  1  one-cycle FIFO write strobe.
REQ-012 data_o  output  BUS_WIDTH  assembled byte presented to the FIFO write data.
REQ-013 byte_cnt  output  10  data bytes written in the current packet.
REQ-014 pkt_done  output  1  one-cycle good-packet strobe.
REQ-015 rx_error  output  1  sticky packet error flag.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement states IDLE, DATA, ERR.
REQ-018 SHALL shift bits LSB-first: on each bit_valid, shift_reg <= {d_bit, shift_reg[7:1]}, in every state.
REQ-019 IDLE: when the post-shift value equals SYNC_PATTERN, SHALL go to DATA, zero bit_cnt and byte_cnt, and clear rx_error.
REQ-020 DATA: SHALL count bits 0..7 in a 3-bit bit_cnt, which wraps to 0 after the 8th bit.
REQ-021 DATA, 8th bit with fifo_full=0: SHALL load data_o with the assembled byte and assert w_enable in the next cycle only (1-cycle latency).
REQ-022 SHALL increment byte_cnt in the w_enable cycle, saturating at MAX_BYTES.
REQ-023 data_o SHALL hold its value until the next completed byte.
REQ-024 DATA, 8th bit with fifo_full=1: SHALL NOT assert w_enable, SHALL set rx_error, and SHALL go to ERR.
REQ-025 DATA, byte completing with byte_cnt already at MAX_BYTES: SHALL be treated as overflow exactly as in REQ-024.
REQ-026 DATA, eop with bit_cnt=0: SHALL pulse pkt_done the next cycle and return to IDLE.
REQ-027 DATA, eop with bit_cnt!=0 (partial byte): SHALL set rx_error, SHALL NOT pulse pkt_done, and SHALL return to IDLE.
REQ-028 eop and bit_valid in the same cycle: eop SHALL take priority and the bit SHALL be discarded.
REQ-029 ERR: SHALL ignore data, go to IDLE on eop, and SHALL NOT assert w_enable or pkt_done.
REQ-030 eop in IDLE SHALL be ignored.
REQ-031 rx_error SHALL remain set until the next SYNC detect, clear, or reset.
REQ-032 clear SHALL override all other inputs: state IDLE, shift_reg/bit_cnt/byte_cnt zeroed, rx_error cleared, no strobe issued.
REQ-033 w_enable and pkt_done SHALL never be high in the same cycle.

Reset
REQ-034 On n_rst=0, asynchronously: state=IDLE, shift_reg=0, bit_cnt=0, byte_cnt=0, data_o=0, w_enable=0, pkt_done=0, rx_error=0, busy=0.
REQ-035 Reset asserted mid-packet SHALL drop any partial byte, and no w_enable SHALL follow reset release.

Verification
REQ-036 Bits 0,0,0,0,0,0,0,1 then bytes 0xA5, 0x3C, then eop -> w_enable twice with data_o=0xA5 then 0x3C, byte_cnt=2, pkt_done one cycle after eop, rx_error=0.
REQ-037 SYNC, then 3 bits, then eop -> rx_error=1, no pkt_done, state IDLE, byte_cnt=0.
REQ-038 SYNC, fifo_full=1 at the 8th bit of the first byte -> no w_enable, rx_error=1; further bits are ignored until eop; next SYNC clears rx_error.
REQ-039 SYNC, 7 bits, then eop and bit_valid in the same cycle -> bit discarded, rx_error=1, no w_enable.
REQ-040 n_rst pulsed low after 4 data bits -> all outputs at reset values immediately; the next 4 bits produce no w_enable.
REQ-041 clear asserted with bit_valid in DATA -> IDLE next cycle, busy=0, byte_cnt=0, no strobe.
